fpu_ex_seq: RTL and testbench

Next-generation FPU execute stage. It replaces the purely combinational move-only unit with a registered, multi-cycle unit. It keeps MTC/MFC and adds MOV, ABS and NEG, plus an iterative CVT.S.W (int32 to single) with FCSR rounding modes, an inexact flag, and a real busy/done handshake. It sits in the EX stage beside the integer ALU; the pipeline stalls while is_busy is high.

---
 rtl/fpu_ex_seq_if.sv | 48 ++++
 rtl/fpu_ex_seq.sv | 81 ++++++++
 tb/tb_fpu_ex_seq.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_ex_seq_if.sv
// fpu_ex_seq_if: FPU execute-stage operand/result types and request/response bundle
package fpu_ex_seq_pkg;
  typedef enum logic [2:0] {
    FPU_OP_NOP   = 3'd0,
    FPU_OP_MTC   = 3'd1,
    FPU_OP_MFC   = 3'd2,
    FPU_OP_MOV   = 3'd3,
    FPU_OP_ABS   = 3'd4,
    FPU_OP_NEG   = 3'd5,
    FPU_OP_CVTSW = 3'd6
  } FPUOper_t;
  typedef struct packed {
    logic [29:0] rsvd;
    logic [1:0]  rm;
  } FCSRReg_t;
  typedef logic [31:0] FPUReg_t;
  typedef struct packed {
    logic invalid;
    logic div_zero;
    logic overflow;
    logic underflow;
    logic inexact;
  } FPUExcept_t;
endpackage

interface fpu_ex_seq_if;
  import fpu_ex_seq_pkg::*;
  logic        start;
  FPUOper_t    op;
  FCSRReg_t    fcsr;
  logic [31:0] gpr1;
  logic [31:0] gpr2;
  FPUReg_t     reg1;
  FPUReg_t     reg2;
  FPUReg_t     fpu_ret;
  logic [31:0] cpu_ret;
  FPUExcept_t  except;
  logic        is_busy;
  logic        done;
  modport master (
    output start, op, fcsr, gpr1, gpr2, reg1, reg2,
    input  fpu_ret, cpu_ret, except, is_busy, done
  );
  modport slave (
    input  start, op, fcsr, gpr1, gpr2, reg1, reg2,
    output fpu_ret, cpu_ret, except, is_busy, done
  );
endinterface

// File: rtl/fpu_ex_seq.sv
// fpu_ex_seq: registered FPU execute stage with moves, sign ops and iterative int32-to-single conversion
module fpu_ex_seq
  import fpu_ex_seq_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NORM_STEP = 1
) (
  input  logic         clk,
  input  logic         rst,
  fpu_ex_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, NORM, ROUND} state_t;
  state_t            state, state_n;
  logic              s;
  logic [1:0]        rm;
  logic [31:0]       m, m_sh;
  logic [7:0]        e;
  logic [WIDTH-1:0]  mag;
  logic [5:0]        lz;
  logic [3:0]        k;
  logic              accept, cvt_go, g, st, inc;
  logic [24:0]       sum;
  logic              unused_ok;
  assign unused_ok   = ^{bus.gpr1, bus.reg1, bus.fcsr.rsvd};
  assign mag         = bus.reg2[31] ? -bus.reg2 : bus.reg2;
  assign accept      = bus.start && state == IDLE;
  assign cvt_go      = accept && bus.op == FPU_OP_CVTSW && mag != '0;
  assign bus.is_busy = state != IDLE;
  assign g           = m[7];
  assign st          = |m[6:0];
  assign inc         = rm == 2'd0 ? g & (st | m[8]) : rm == 2'd1 ? 1'b0 : rm == 2'd2 ? ~s & (g | st) : s & (g | st);
  assign sum         = {1'b0, m[31:8]} + 25'(inc);
  always_comb begin
    lz = 6'd32;
    for (int i = 0; i < 32; i++) if (m[i]) lz = 6'(31 - i);
    k = (lz > 6'(NORM_STEP)) ? 4'(NORM_STEP) : lz[3:0];
    m_sh = m << k;
    state_n = state == IDLE ? (cvt_go ? NORM : IDLE) : state == NORM ? (m_sh[31] ? ROUND : NORM) : IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fpu_ret <= '0;
      bus.cpu_ret <= '0;
      bus.except  <= '0;
      bus.done    <= 1'b0;
      s <= 1'b0;
      rm <= 2'd0;
      m <= '0;
      e <= '0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        bus.except <= '0;
        bus.done   <= !cvt_go;
        s  <= bus.reg2[31];
        rm <= bus.fcsr.rm;
        m  <= mag;
        e  <= 8'd158;
        case (bus.op)
          FPU_OP_MTC:   bus.fpu_ret <= bus.gpr2;
          FPU_OP_MFC:   bus.cpu_ret <= bus.reg2;
          FPU_OP_MOV:   bus.fpu_ret <= bus.reg2;
          FPU_OP_ABS:   bus.fpu_ret <= {1'b0, bus.reg2[30:0]};
          FPU_OP_NEG:   bus.fpu_ret <= {~bus.reg2[31], bus.reg2[30:0]};
          FPU_OP_CVTSW: if (mag == '0) bus.fpu_ret <= '0;
          default: ;
        endcase
      end
      if (state == NORM) begin
        m <= m_sh;
        e <= e - 8'(k);
      end
      if (state == ROUND) begin
        bus.fpu_ret        <= {s, e + 8'(sum[24]), sum[22:0]};
        bus.except.inexact <= g | st;
        bus.done           <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fpu_ex_seq.sv
// tb_fpu_ex_seq: vector table, hand sequences and random ops against an arithmetic conversion model
module tb_fpu_ex_seq;
  import fpu_ex_seq_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fpu_ex_seq_if b1();
  fpu_ex_seq_if b8();
  assign b8.start = b1.start;
  assign b8.op    = b1.op;
  assign b8.fcsr  = b1.fcsr;
  assign b8.gpr1  = b1.gpr1;
  assign b8.gpr2  = b1.gpr2;
  assign b8.reg1  = b1.reg1;
  assign b8.reg2  = b1.reg2;
  fpu_ex_seq #(.WIDTH(32), .NORM_STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  fpu_ex_seq #(.WIDTH(32), .NORM_STEP(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
  int total = 0;
  int passed = 0;
  logic [31:0] hf = '0;
  logic [31:0] hc = '0;
  typedef struct {
    FPUOper_t    op;
    logic [1:0]  rm;
    logic [31:0] g2;
    logic [31:0] r2;
    logic [31:0] ef;
    logic [31:0] ec;
    logic        ei;
  } vec_t;
  vec_t tbl[16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic logic [63:0] magnitude(input logic [31:0] x);
    return x[31] ? 64'h1_0000_0000 - {32'b0, x} : {32'b0, x};
  endfunction
  function automatic int msb(input logic [63:0] v);
    int p = -1;
    for (int i = 0; i < 64; i++) if (v[i]) p = i;
    return p;
  endfunction
  function automatic logic [32:0] ref_cvt(input logic [31:0] x, input logic [1:0] rm);
    logic [63:0] mg, q, rem, half;
    int p, sh, ex;
    logic inx, up;
    mg = magnitude(x);
    if (mg == 0) return 33'd0;
    p = msb(mg);
    ex = 127 + p;
    inx = 1'b0;
    if (p <= 23) q = mg << (23 - p);
    else begin
      sh = p - 23;
      q = mg >> sh;
      rem = mg - (q << sh);
      half = 64'd1 << (sh - 1);
      inx = rem != 0;
      case (rm)
        2'd0: up = (rem > half) || (rem == half && q[0]);
        2'd1: up = 1'b0;
        2'd2: up = !x[31] && inx;
        default: up = x[31] && inx;
      endcase
      q = q + 64'(up);
      if (q == 64'd1 << 24) begin
        q = 64'd1 << 23;
        ex++;
      end
    end
    return {inx, x[31], 8'(ex), q[22:0]};
  endfunction
  function automatic int busy_len(input FPUOper_t op, input logic [31:0] x, input int step);
    logic [63:0] mg;
    int lz, n;
    mg = magnitude(x);
    if (op != FPU_OP_CVTSW || mg == 0) return 0;
    lz = 31 - msb(mg);
    n = (lz + step - 1) / step;
    if (n < 1) n = 1;
    return n + 1;
  endfunction
  task automatic drive(input FPUOper_t op, input logic [1:0] rm, input logic [31:0] g2, input logic [31:0] r2);
    b1.op = op;
    b1.fcsr = FCSRReg_t'({30'b0, rm});
    b1.gpr2 = g2;
    b1.reg2 = r2;
    b1.gpr1 = $urandom;
    b1.reg1 = $urandom;
  endtask
  task automatic run_op(input string tag, input FPUOper_t op, input logic [1:0] rm, input logic [31:0] g2,
                        input logic [31:0] r2, input logic [31:0] ef, input logic [31:0] ec, input logic ei);
    int t, d1, d8, z1, z8, ov;
    logic [31:0] f1, c1, f8, c8;
    logic x1, x8;
    t = 0; d1 = -1; d8 = -1; z1 = 0; z8 = 0; ov = 0;
    f1 = 'x; c1 = 'x; f8 = 'x; c8 = 'x; x1 = 1'bx; x8 = 1'bx;
    @(negedge clk);
    drive(op, rm, g2, r2);
    b1.start = 1'b1;
    @(posedge clk);
    #1 b1.start = 1'b0;
    while ((d1 < 0 || d8 < 0) && t < 80) begin
      if (b1.is_busy) z1++;
      if (b8.is_busy) z8++;
      if ((b1.done && b1.is_busy) || (b8.done && b8.is_busy)) ov++;
      if (b1.done && d1 < 0) begin d1 = t; f1 = b1.fpu_ret; c1 = b1.cpu_ret; x1 = b1.except.inexact; end
      if (b8.done && d8 < 0) begin d8 = t; f8 = b8.fpu_ret; c8 = b8.cpu_ret; x8 = b8.except.inexact; end
      @(posedge clk);
      #1 t++;
    end
    chk({tag, " done_at1"}, 32'(d1), 32'(busy_len(op, r2, 1)));
    chk({tag, " done_at8"}, 32'(d8), 32'(busy_len(op, r2, 8)));
    chk({tag, " busy1"}, 32'(z1), 32'(busy_len(op, r2, 1)));
    chk({tag, " busy8"}, 32'(z8), 32'(busy_len(op, r2, 8)));
    chk({tag, " done_busy_overlap"}, 32'(ov), 32'd0);
    chk({tag, " fpu1"}, f1, ef);
    chk({tag, " fpu8"}, f8, ef);
    chk({tag, " cpu1"}, c1, ec);
    chk({tag, " cpu8"}, c8, ec);
    chk({tag, " inexact1"}, {31'b0, x1}, {31'b0, ei});
    chk({tag, " inexact8"}, {31'b0, x8}, {31'b0, ei});
    hf = ef;
    hc = ec;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " fpu1"}, b1.fpu_ret, 32'h0);
    chk({tag, " fpu8"}, b8.fpu_ret, 32'h0);
    chk({tag, " cpu1"}, b1.cpu_ret, 32'h0);
    chk({tag, " cpu8"}, b8.cpu_ret, 32'h0);
    chk({tag, " except"}, {27'b0, b1.except | b8.except}, 32'h0);
    chk({tag, " busy"}, {30'b0, b1.is_busy, b8.is_busy}, 32'h0);
    chk({tag, " done"}, {30'b0, b1.done, b8.done}, 32'h0);
  endtask
  initial begin
    int n, dn;
    logic [31:0] x, ef, ec;
    logic [32:0] r;
    logic ei;
    FPUOper_t op;
    logic [1:0] rm;
    b1.start = 1'b0;
    drive(FPU_OP_NOP, 2'd0, 32'h0, 32'h0);
    tbl[0]  = '{FPU_OP_MTC,   2'd0, 32'h12345678, 32'h0,        32'h12345678, 32'h0,        1'b0};
    tbl[1]  = '{FPU_OP_ABS,   2'd0, 32'h0,        32'hC0000000, 32'h40000000, 32'h0,        1'b0};
    tbl[2]  = '{FPU_OP_NEG,   2'd0, 32'h0,        32'h3F800000, 32'hBF800000, 32'h0,        1'b0};
    tbl[3]  = '{FPU_OP_MFC,   2'd0, 32'h0,        32'hDEADBEEF, 32'hBF800000, 32'hDEADBEEF, 1'b0};
    tbl[4]  = '{FPU_OP_MOV,   2'd0, 32'h0,        32'h7FC00001, 32'h7FC00001, 32'hDEADBEEF, 1'b0};
    tbl[5]  = '{FPU_OP_CVTSW, 2'd0, 32'h0,        32'h00000001, 32'h3F800000, 32'hDEADBEEF, 1'b0};
    tbl[6]  = '{FPU_OP_CVTSW, 2'd0, 32'h0,        32'hFFFFFFFF, 32'hBF800000, 32'hDEADBEEF, 1'b0};
    tbl[7]  = '{FPU_OP_CVTSW, 2'd0, 32'h0,        32'h00000000, 32'h00000000, 32'hDEADBEEF, 1'b0};
    tbl[8]  = '{FPU_OP_CVTSW, 2'd0, 32'h0,        32'h80000000, 32'hCF000000, 32'hDEADBEEF, 1'b0};
    tbl[9]  = '{FPU_OP_CVTSW, 2'd0, 32'h0,        32'h01000001, 32'h4B800000, 32'hDEADBEEF, 1'b1};
    tbl[10] = '{FPU_OP_CVTSW, 2'd2, 32'h0,        32'h01000001, 32'h4B800001, 32'hDEADBEEF, 1'b1};
    tbl[11] = '{FPU_OP_CVTSW, 2'd1, 32'h0,        32'h01000001, 32'h4B800000, 32'hDEADBEEF, 1'b1};
    tbl[12] = '{FPU_OP_CVTSW, 2'd0, 32'h0,        32'h7FFFFFFF, 32'h4F000000, 32'hDEADBEEF, 1'b1};
    tbl[13] = '{FPU_OP_CVTSW, 2'd0, 32'h0,        32'h01000003, 32'h4B800002, 32'hDEADBEEF, 1'b1};
    tbl[14] = '{FPU_OP_CVTSW, 2'd3, 32'h0,        32'hFEFFFFFF, 32'hCB800001, 32'hDEADBEEF, 1'b1};
    tbl[15] = '{FPU_OP_NOP,   2'd0, 32'h11111111, 32'h22222222, 32'hCB800001, 32'hDEADBEEF, 1'b0};
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 16; i++) run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].rm, tbl[i].g2, tbl[i].r2, tbl[i].ef, tbl[i].ec, tbl[i].ei);
    @(negedge clk);
    drive(FPU_OP_MFC, 2'd0, 32'h0, 32'hA5A5A5A5);
    b1.start = 1'b1;
    @(posedge clk);
    #1 chk("b2b_single done", {30'b0, b1.done, b8.done}, 32'h3);
    chk("b2b_single cpu", b1.cpu_ret & b8.cpu_ret, 32'hA5A5A5A5);
    drive(FPU_OP_MTC, 2'd0, 32'h0F0F0F0F, 32'h0);
    @(posedge clk);
    #1 b1.start = 1'b0;
    chk("b2b_single done2", {30'b0, b1.done, b8.done}, 32'h3);
    chk("b2b_single fpu1", b1.fpu_ret, 32'h0F0F0F0F);
    chk("b2b_single fpu8", b8.fpu_ret, 32'h0F0F0F0F);
    @(negedge clk);
    drive(FPU_OP_CVTSW, 2'd0, 32'h0, 32'h00000001);
    b1.start = 1'b1;
    @(posedge clk);
    #1 drive(FPU_OP_MTC, 2'd0, 32'hAAAAAAAA, 32'h0);
    repeat (3) @(posedge clk);
    #1 b1.start = 1'b0;
    n = 0;
    while (!b1.done && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    chk("held_start done_seen", {31'b0, b1.done}, 32'h1);
    chk("held_start fpu1", b1.fpu_ret, 32'h3F800000);
    chk("held_start fpu8", b8.fpu_ret, 32'h3F800000);
    drive(FPU_OP_CVTSW, 2'd0, 32'h0, 32'h01000003);
    b1.start = 1'b1;
    @(posedge clk);
    #1 b1.start = 1'b0;
    n = 0;
    while (!b1.done && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    chk("b2b_cvt fpu1", b1.fpu_ret, 32'h4B800002);
    drive(FPU_OP_MTC, 2'd0, 32'h55555555, 32'h0);
    b1.start = 1'b1;
    @(posedge clk);
    #1 b1.start = 1'b0;
    chk("b2b_cvt done2", {30'b0, b1.done, b8.done}, 32'h3);
    chk("b2b_cvt fpu1_next", b1.fpu_ret, 32'h55555555);
    chk("b2b_cvt fpu8_next", b8.fpu_ret, 32'h55555555);
    @(negedge clk);
    drive(FPU_OP_CVTSW, 2'd0, 32'h0, 32'h00000001);
    b1.start = 1'b1;
    @(negedge clk) b1.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_zero("mid_reset");
    @(negedge clk) rst = 1'b0;
    dn = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (b1.done || b8.done) dn++;
    end
    chk("mid_reset no_done", 32'(dn), 32'h0);
    hf = '0;
    hc = '0;
    run_op("post_reset", FPU_OP_MTC, 2'd0, 32'h0BADF00D, 32'h0, 32'h0BADF00D, 32'h0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      op = FPUOper_t'($urandom_range(0, 6));
      rm = 2'($urandom_range(0, 3));
      x = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) x = -x;
      if (op != FPU_OP_CVTSW && $urandom_range(0, 1) == 1) x = $urandom;
      ef = hf;
      ec = hc;
      ei = 1'b0;
      case (op)
        FPU_OP_MTC: ef = x ^ 32'h5A5A0000;
        FPU_OP_MFC: ec = x;
        FPU_OP_MOV: ef = x;
        FPU_OP_ABS: ef = {1'b0, x[30:0]};
        FPU_OP_NEG: ef = {~x[31], x[30:0]};
        FPU_OP_CVTSW: begin
          r = ref_cvt(x, rm);
          ef = r[31:0];
          ei = r[32];
        end
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), op, rm, x ^ 32'h5A5A0000, x, ef, ec, ei);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
